if_scratch_ring_writer: RTL and testbench

Parametrised successor of the IF buffer read/scratch fill controller. Drains words from the IF input buffer (first-word-fall-through) into a circular scratchpad and tracks up to MAX_ROWS completed rows in an internal end-pointer queue. Applies backpressure when the scratchpad or the row queue is full, and releases the oldest row on the consumer's `full_done`. Sits between the IF input buffer and the IF scratchpad, and feeds the PE controller's start/end window.

---
 rtl/if_scratch_ring_writer.sv | 218 +++++++++++++++++++++
 tb/tb_if_scratch_ring_writer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_scratch_ring_writer.sv
// if_scratch_ring_writer
//   Drains a first-word-fall-through input buffer into a circular scratchpad.
//   Completed rows are tracked as end pointers in a small queue. The oldest row
//   is presented to the PE controller as a [start_if_o, end_if_o] window and is
//   released on full_done_i.
//
// Configuration macro: IF_FULL_STALL_EN
//   defined   : a full scratchpad stalls the input and if_overflow_o stays 0.
//   undefined : writes continue while full and overwrite the oldest data;
//               the occupancy count saturates and if_overflow_o is set (sticky).
//
// Ports
//   clk_i, rst_ni          clock, synchronous active-low reset
//   start_i, stop_i        session start (IDLE only) / end request (ACTIVE only)
//   if_buf_empty_flag_i    input buffer empty
//   if_buf_end_flag_i      head word closes a row
//   if_buf_data_i          head word of the input buffer
//   full_done_i            consumer finished the oldest row
//   if_buf_read_o          pop the input buffer
//   if_scratch_wen_o       scratchpad write enable
//   if_waddr_o, if_wdata_o scratchpad write address / data
//   start_if_o, end_if_o   window of the oldest held row
//   if_end_valid_o         at least one complete row is held
//   if_full_o              occupancy == SCRATCH_DEPTH
//   if_count_o             occupied entries, including the partial row
//   if_overflow_o          sticky overwrite error
//   busy_o                 not IDLE
module if_scratch_ring_writer #(
   parameter int unsigned ADDR_LEN      = 4,
   parameter int unsigned SCRATCH_DEPTH = 16,
   parameter int unsigned SCRATCH_WIDTH = 16,
   parameter int unsigned MAX_ROWS      = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic                     stop_i,
   input  logic                     if_buf_empty_flag_i,
   input  logic                     if_buf_end_flag_i,
   input  logic [SCRATCH_WIDTH-1:0] if_buf_data_i,
   input  logic                     full_done_i,
   output logic                     if_buf_read_o,
   output logic                     if_scratch_wen_o,
   output logic [ADDR_LEN-1:0]      if_waddr_o,
   output logic [SCRATCH_WIDTH-1:0] if_wdata_o,
   output logic [ADDR_LEN-1:0]      start_if_o,
   output logic [ADDR_LEN-1:0]      end_if_o,
   output logic                     if_end_valid_o,
   output logic                     if_full_o,
   output logic [ADDR_LEN:0]        if_count_o,
   output logic                     if_overflow_o,
   output logic                     busy_o
);

   localparam int unsigned CW   = ADDR_LEN + 1;
   localparam int unsigned RowW = $clog2(MAX_ROWS + 1);

   localparam logic [CW-1:0]       DepthC   = CW'(SCRATCH_DEPTH);
   localparam logic [CW-1:0]       OneC     = CW'(1);
   localparam logic [ADDR_LEN-1:0] LastAddr = ADDR_LEN'(SCRATCH_DEPTH - 1);
   localparam logic [ADDR_LEN-1:0] OneA     = ADDR_LEN'(1);
   localparam logic [RowW-1:0]     MaxRowsC = RowW'(MAX_ROWS);
   localparam logic [RowW-1:0]     OneR     = RowW'(1);

   typedef enum logic [1:0] {StIdle, StInit, StActive, StDrain} state_e;

   state_e              state_q, state_d;
   logic [ADDR_LEN-1:0] waddr_q, waddr_d;
   logic [ADDR_LEN-1:0] start_ptr_q, start_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic [ADDR_LEN-1:0] row_q [MAX_ROWS];
   logic [ADDR_LEN-1:0] row_d [MAX_ROWS];
   logic [RowW-1:0]     rows_q, rows_d;
   logic                ovf_q, ovf_d;

   logic                end_valid, pop, push, full, q_full, stall, acc;
   logic [ADDR_LEN-1:0] head, waddr_inc, head_inc;
   logic [CW-1:0]       row_len, cnt_up, cnt_rel;
   logic [RowW-1:0]     push_idx;

   assign end_valid = (rows_q != '0);
   assign head      = end_valid ? row_q[0] : '0;
   assign pop       = full_done_i & end_valid;
   assign full      = (count_q == DepthC);
   // A full row queue only blocks when no row leaves in the same cycle.
   assign q_full    = (rows_q == MaxRowsC) & ~pop;
`ifdef IF_FULL_STALL_EN
   assign stall     = full | q_full;
`else
   assign stall     = q_full;
`endif
   assign acc       = (state_q == StActive) & ~if_buf_empty_flag_i & ~stall;
   assign push      = acc & if_buf_end_flag_i;

   assign waddr_inc = (waddr_q == LastAddr) ? '0 : waddr_q + OneA;
   assign head_inc  = (head == LastAddr) ? '0 : head + OneA;

   // Row length of the oldest row, ring distance computed one bit wider.
   always_comb begin
      row_len = '0;
      if ({1'b0, head} >= {1'b0, start_ptr_q}) begin
         row_len = {1'b0, head} - {1'b0, start_ptr_q} + OneC;
      end else begin
         row_len = {1'b0, head} + DepthC - {1'b0, start_ptr_q} + OneC;
      end
   end

   // Occupancy: add the write, subtract a released row, clamp to [0, depth].
   always_comb begin
      cnt_up  = count_q + (acc ? OneC : '0);
      cnt_rel = cnt_up;
      if (pop) begin
         cnt_rel = (cnt_up >= row_len) ? cnt_up - row_len : '0;
      end
   end

   assign push_idx = rows_q - (pop ? OneR : '0);

   always_comb begin
      state_d     = state_q;
      waddr_d     = waddr_q;
      start_ptr_d = start_ptr_q;
      count_d     = (cnt_rel > DepthC) ? DepthC : cnt_rel;
      row_d       = row_q;
      rows_d      = rows_q + (push ? OneR : '0) - (pop ? OneR : '0);
`ifdef IF_FULL_STALL_EN
      ovf_d       = 1'b0;
`else
      ovf_d       = ovf_q | (acc & full);
`endif

      if (acc) begin
         waddr_d = waddr_inc;
      end

      // Queue is a shift register with the oldest row at index 0.
      if (pop) begin
         for (int i = 0; i < int'(MAX_ROWS) - 1; i++) begin
            row_d[i] = row_q[i+1];
         end
         row_d[MAX_ROWS-1] = '0;
         start_ptr_d       = head_inc;
      end
      if (push) begin
         for (int i = 0; i < int'(MAX_ROWS); i++) begin
            if (RowW'(i) == push_idx) begin
               row_d[i] = waddr_q;
            end
         end
      end

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StInit;
            end
         end
         StInit: begin
            state_d     = StActive;
            waddr_d     = '0;
            start_ptr_d = '0;
            count_d     = '0;
            rows_d      = '0;
            ovf_d       = 1'b0;
            for (int i = 0; i < int'(MAX_ROWS); i++) begin
               row_d[i] = '0;
            end
         end
         StActive: begin
            if (stop_i) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            // With no rows held, count_q is exactly the partial row.
            if ((rows_q == '0) && (count_q == '0)) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         waddr_q     <= '0;
         start_ptr_q <= '0;
         count_q     <= '0;
         rows_q      <= '0;
         ovf_q       <= 1'b0;
         for (int i = 0; i < int'(MAX_ROWS); i++) begin
            row_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         waddr_q     <= waddr_d;
         start_ptr_q <= start_ptr_d;
         count_q     <= count_d;
         rows_q      <= rows_d;
         ovf_q       <= ovf_d;
         row_q       <= row_d;
      end
   end

   assign if_buf_read_o    = acc;
   assign if_scratch_wen_o = acc;
   assign if_waddr_o       = waddr_q;
   assign if_wdata_o       = acc ? if_buf_data_i : '0;
   assign start_if_o       = start_ptr_q;
   assign end_if_o         = head;
   assign if_end_valid_o   = end_valid;
   assign if_full_o        = full;
   assign if_count_o       = count_q;
   assign if_overflow_o    = ovf_q;
   assign busy_o           = (state_q != StIdle);

endmodule

// File: tb/tb_if_scratch_ring_writer.sv
module tb_if_scratch_ring_writer;

   localparam int D  = 16;
   localparam int MR = 4;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic        stop_i = 1'b0;
   logic        if_buf_empty_flag_i = 1'b1;
   logic        if_buf_end_flag_i = 1'b0;
   logic [15:0] if_buf_data_i = '0;
   logic        full_done_i = 1'b0;
   logic        if_buf_read_o, if_scratch_wen_o;
   logic [3:0]  if_waddr_o;
   logic [15:0] if_wdata_o;
   logic [3:0]  start_if_o, end_if_o;
   logic        if_end_valid_o, if_full_o;
   logic [4:0]  if_count_o;
   logic        if_overflow_o, busy_o;

   if_scratch_ring_writer #(
      .ADDR_LEN(4), .SCRATCH_DEPTH(D), .SCRATCH_WIDTH(16), .MAX_ROWS(MR)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .stop_i(stop_i),
      .if_buf_empty_flag_i(if_buf_empty_flag_i), .if_buf_end_flag_i(if_buf_end_flag_i),
      .if_buf_data_i(if_buf_data_i), .full_done_i(full_done_i),
      .if_buf_read_o(if_buf_read_o), .if_scratch_wen_o(if_scratch_wen_o),
      .if_waddr_o(if_waddr_o), .if_wdata_o(if_wdata_o),
      .start_if_o(start_if_o), .end_if_o(end_if_o), .if_end_valid_o(if_end_valid_o),
      .if_full_o(if_full_o), .if_count_o(if_count_o), .if_overflow_o(if_overflow_o),
      .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   int vecs = 0;
   int fails = 0;

   // Reference model: 0 idle, 1 init, 2 active, 3 drain.
   int          m_state, m_waddr, m_start, m_count, m_ovf;
   int          m_rows[$];
   logic [15:0] s_data[$];
   bit          s_end[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_waddr = 0; m_start = 0; m_count = 0; m_ovf = 0;
      m_rows.delete();
   endtask

   task automatic feed(input int n, input bit end_last);
      for (int i = 0; i < n; i++) begin
         s_data.push_back(16'($urandom));
         s_end.push_back(end_last && (i == n - 1));
      end
   endtask

   // One clock: drive inputs, compare at the falling edge, advance the model.
   task automatic step(input bit fd, input bit st, input bit sp);
      bit empty, pop, full, stall, acc, endf;
      int head, len, nstate;
      logic [15:0] wd;
      empty = (s_data.size() == 0);
      wd    = empty ? 16'h0 : s_data[0];
      endf  = empty ? 1'b0 : s_end[0];
      start_i = st; stop_i = sp; full_done_i = fd;
      if_buf_empty_flag_i = empty; if_buf_data_i = wd; if_buf_end_flag_i = endf;
      @(negedge clk_i);
      pop   = fd && (m_rows.size() > 0);
      head  = (m_rows.size() > 0) ? m_rows[0] : 0;
      full  = (m_count == D);
      stall = (m_rows.size() == MR) && !pop;
`ifdef IF_FULL_STALL_EN
      stall = stall || full;
`endif
      acc = (m_state == 2) && !empty && !stall;
      chk("read",   32'(if_buf_read_o),    32'(acc));
      chk("wen",    32'(if_scratch_wen_o), 32'(acc));
      chk("waddr",  32'(if_waddr_o),       m_waddr);
      chk("wdata",  32'(if_wdata_o),       acc ? 32'(wd) : 0);
      chk("start",  32'(start_if_o),       m_start);
      chk("end",    32'(end_if_o),         head);
      chk("valid",  32'(if_end_valid_o),   32'(m_rows.size() > 0));
      chk("full",   32'(if_full_o),        32'(full));
      chk("count",  32'(if_count_o),       m_count);
      chk("ovf",    32'(if_overflow_o),    m_ovf);
      chk("busy",   32'(busy_o),           32'(m_state != 0));
      @(posedge clk_i);
      if (!rst_ni) begin
         model_reset();
      end else begin
         case (m_state)
            0: nstate = st ? 1 : 0;
            1: nstate = 2;
            2: nstate = sp ? 3 : 2;
            default: nstate = (m_rows.size() == 0 && m_count == 0) ? 0 : 3;
         endcase
         if (m_state == 1) begin
            model_reset();
         end else begin
            len = pop ? ((head - m_start + D) % D) + 1 : 0;
            if (pop) begin
               void'(m_rows.pop_front());
               m_start = (head + 1) % D;
            end
            if (acc) begin
`ifndef IF_FULL_STALL_EN
               if (full) m_ovf = 1;
`endif
               if (endf) m_rows.push_back(m_waddr);
               m_waddr = (m_waddr + 1) % D;
            end
            m_count = m_count + int'(acc) - len;
            if (m_count < 0) m_count = 0;
            if (m_count > D) m_count = D;
         end
         m_state = nstate;
      end
      if (acc) begin
         void'(s_data.pop_front());
         void'(s_end.pop_front());
      end
      #1;
   endtask

   task automatic restart();
      step(0, 0, 1);  // ACTIVE -> DRAIN
      step(0, 0, 0);  // DRAIN -> IDLE (nothing held)
      chk("idle_busy", 32'(busy_o), 0);
      step(0, 1, 0);  // IDLE -> INIT
      step(0, 0, 0);  // INIT -> ACTIVE
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      step(0, 0, 0);
      chk("rst_busy",  32'(busy_o), 0);
      chk("rst_count", 32'(if_count_o), 0);
      rst_ni = 1'b1;
      step(0, 1, 0);
      step(0, 0, 0);

      // Basic row of four words.
      feed(4, 1);
      repeat (4) step(0, 0, 0);
      chk("basic_valid", 32'(if_end_valid_o), 1);
      chk("basic_start", 32'(start_if_o), 0);
      chk("basic_end",   32'(end_if_o), 3);
      chk("basic_count", 32'(if_count_o), 4);

      // Release, then a full_done with nothing held.
      step(1, 0, 0);
      chk("rel_start", 32'(start_if_o), 4);
      chk("rel_count", 32'(if_count_o), 0);
      chk("rel_valid", 32'(if_end_valid_o), 0);
      step(1, 0, 0);
      chk("rel2_start", 32'(start_if_o), 4);

      // Three rows of six crossing the wrap point.
      restart();
      chk("init_waddr", 32'(if_waddr_o), 0);
      for (int r = 0; r < 3; r++) begin
         feed(6, 1);
         repeat (6) step(0, 0, 0);
         if (r == 2) begin
            chk("wrap_end",   32'(end_if_o), 1);
            chk("wrap_start", 32'(start_if_o), 12);
         end
         step(1, 0, 0);
      end
      chk("wrap_rel_start", 32'(start_if_o), 2);

      // Sixteen words without release, then a seventeenth.
      restart();
      feed(4, 1);
      feed(12, 0);
      repeat (16) step(0, 0, 0);
      chk("fill_full",  32'(if_full_o), 1);
      chk("fill_count", 32'(if_count_o), 16);
      feed(1, 0);
      step(0, 0, 0);
`ifdef IF_FULL_STALL_EN
      chk("stall_read",  32'(if_buf_read_o), 0);
      chk("stall_waddr", 32'(if_waddr_o), 0);
      chk("stall_ovf",   32'(if_overflow_o), 0);
      step(1, 0, 0);
      step(0, 0, 0);
      chk("resume_waddr", 32'(if_waddr_o), 1);
      chk("resume_count", 32'(if_count_o), 13);
`else
      chk("ovf_flag",  32'(if_overflow_o), 1);
      chk("ovf_count", 32'(if_count_o), 16);
      chk("ovf_waddr", 32'(if_waddr_o), 1);
      step(1, 0, 0);
      chk("ovf_rel_count", 32'(if_count_o), 12);
      chk("ovf_sticky",    32'(if_overflow_o), 1);
`endif

      // Reset in the middle of a partial row.
      feed(2, 0);
      repeat (2) step(0, 0, 0);
      rst_ni = 1'b0;
      step(0, 0, 0);
      rst_ni = 1'b1;
      chk("mrst_busy",  32'(busy_o), 0);
      chk("mrst_waddr", 32'(if_waddr_o), 0);
      chk("mrst_start", 32'(start_if_o), 0);
      chk("mrst_end",   32'(end_if_o), 0);
      chk("mrst_valid", 32'(if_end_valid_o), 0);
      chk("mrst_count", 32'(if_count_o), 0);
      chk("mrst_ovf",   32'(if_overflow_o), 0);
      s_data.delete();
      s_end.delete();
      step(0, 1, 0);
      step(0, 0, 0);

      // Full row queue: stall, then push and pop in the same cycle.
      repeat (4) feed(2, 1);
      repeat (8) step(0, 0, 0);
      feed(1, 1);
      step(0, 0, 0);
      chk("qfull_read", 32'(if_buf_read_o), 0);
      step(1, 0, 0);
      chk("sim_count", 32'(if_count_o), 7);
      chk("sim_valid", 32'(if_end_valid_o), 1);
      chk("sim_start", 32'(start_if_o), 2);
      chk("sim_end",   32'(end_if_o), 3);
      repeat (4) step(1, 0, 0);
      chk("sim_drain_count", 32'(if_count_o), 0);

      // Random traffic; start pulses while active must be ignored.
      for (int c = 0; c < 400; c++) begin
         if (s_data.size() == 0 && m_count < D && $urandom_range(0, 2) != 0)
            feed(1, $urandom_range(0, 3) == 0);
         step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
